// File: rtl/modn_down_timer_pkg.sv
// Shared types and constants for the mod-N down timer (state enum, mode encodings).
package modn_down_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/modn_step_gen.sv
// Step generator for the down timer. With MODN_DOWN_PRESCALE_EN defined it emits one
// step every PRESCALE enabled cycles; otherwise step is simply enable.
module modn_step_gen #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic enable,
  output logic step
);

`ifdef MODN_DOWN_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt;

  // Counts enabled cycles only, so disabled cycles freeze the phase.
  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      pcnt <= '0;
    end else if (enable) begin
      pcnt <= (pcnt == PMAX) ? '0 : pcnt + 1'b1;
    end
  end

  assign step = enable && (pcnt == PMAX);
`else
  localparam int unused_prescale = PRESCALE;
  logic unused_inputs;
  assign unused_inputs = ^{clk, reset_n, clr};
  assign step = enable;
`endif

endmodule

// File: rtl/modn_down_timer.sv
// Mod-N down-counting timer with one-shot / auto-reload expiry.
// Optional prescaler enabled by defining MODN_DOWN_PRESCALE_EN.
module modn_down_timer
  import modn_down_timer_pkg::*;
#(
  parameter int N        = 10,
  parameter int WIDTH    = $clog2(N),
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tz,
  output logic             done,
  output state_e           state
);

  localparam logic [WIDTH:0]   N_EXT = (WIDTH + 1)'(N);
  localparam logic [WIDTH-1:0] MAX   = WIDTH'(N - 1);

  logic [WIDTH-1:0] reload;
  logic             step;

  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v);
    if ({1'b0, v} >= N_EXT) return MAX;
    return v;
  endfunction

  // load clears the prescaler so the first step is a full period after the load edge.
  modn_step_gen #(
    .PRESCALE(PRESCALE)
  ) u_step_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (load),
    .enable (enable),
    .step   (step)
  );

  // load is a single-cycle strobe with no back-pressure; it wins over any step or expiry.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      count  <= '0;
      reload <= MAX;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            count  <= clamp(load_val);
            reload <= clamp(load_val);
            state  <= RUN;
            busy   <= 1'b1;
          end
        end
        RUN: begin
          if (load) begin
            count  <= clamp(load_val);
            reload <= clamp(load_val);
          end else if (step) begin
            if (count != '0) begin
              count <= count - 1'b1;
            end else begin
              done <= 1'b1;
              if (mode == MODE_RELOAD) begin
                count <= reload;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign tz = busy && (count == '0);

endmodule

// File: tb/tb_modn_down_timer.sv
// Self-checking bench for modn_down_timer: directed scenarios plus randomized traffic
// against a behavioural model of the timer.
module tb_modn_down_timer;
  import modn_down_timer_pkg::*;

  localparam int N        = 10;
  localparam int WIDTH    = 4;
  localparam int PRESCALE = 4;
`ifdef MODN_DOWN_PRESCALE_EN
  localparam int STEP_CYC = PRESCALE;
`else
  localparam int STEP_CYC = 1;
`endif

  logic             clk;
  logic             reset_n;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             enable;
  logic             mode;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tz;
  logic             done;
  state_e           state;

  int checks = 0;
  int errors = 0;

  // Reference model state: remaining count, reload value, running flag,
  // expiry pulse and enabled cycles seen since the last load.
  int m_count  = 0;
  int m_reload = N - 1;
  int m_en     = 0;
  bit m_run    = 0;
  bit m_done   = 0;

  modn_down_timer #(
    .N       (N),
    .WIDTH   (WIDTH),
    .PRESCALE(PRESCALE)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .load_val(load_val),
    .enable  (enable),
    .mode    (mode),
    .count   (count),
    .busy    (busy),
    .tz      (tz),
    .done    (done),
    .state   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic model_edge();
    int lv;
    bit stp;
    lv = (int'(load_val) > N - 1) ? N - 1 : int'(load_val);
    stp = enable && ((m_en % STEP_CYC) == STEP_CYC - 1);
    m_done = 1'b0;
    if (!reset_n) begin
      m_run = 0; m_count = 0; m_reload = N - 1; m_en = 0;
      return;
    end
    if (load) begin
      m_run = 1; m_count = lv; m_reload = lv; m_en = 0;
      return;
    end
    if (enable) m_en++;
    if (m_run && stp) begin
      if (m_count > 0) m_count--;
      else begin
        m_done = 1'b1;
        if (mode) m_count = m_reload;
        else m_run = 0;
      end
    end
  endtask

  function automatic logic [WIDTH+2:0] model_vec();
    return {WIDTH'(m_count), m_run, m_done, m_run && (m_count == 0)};
  endfunction

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      load = 1'($urandom_range(0, 1));
      load_val = WIDTH'($urandom_range(0, 15));
      enable = 1'($urandom_range(0, 1));
      mode = 1'($urandom_range(0, 1));
      cycle();
    end
    checks++;
    if ({count, busy, done, tz} !== {WIDTH'(0), 3'b000}) begin
      errors++;
      $display("FAIL reset_outputs: got count=%0d busy=%0b done=%0b tz=%0b, want 0 0 0 0",
               count, busy, done, tz);
    end
    checks++;
    if (state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d, want IDLE", state);
    end
    reset_n = 1'b1; load = 1'b0; enable = 1'b0; mode = 1'b0;
    cycle();
  endtask

  task automatic test_oneshot();
    int exp_vals[3] = '{2, 1, 0};
    load = 1'b1; load_val = 4'd3; mode = MODE_ONESHOT; enable = 1'b1;
    cycle();
    load = 1'b0;
    checks++;
    if (count !== 4'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_load: got count=%0d busy=%0b, want 3 1", count, busy);
    end
    foreach (exp_vals[k]) begin
      repeat (STEP_CYC) cycle();
      checks++;
      if (count !== WIDTH'(exp_vals[k]) || done !== 1'b0) begin
        errors++;
        $display("FAIL oneshot_count: got count=%0d done=%0b, want %0d 0", count, done, exp_vals[k]);
      end
    end
    repeat (STEP_CYC) cycle();
    checks++;
    if ({count, busy, done, tz} !== {WIDTH'(0), 3'b010}) begin
      errors++;
      $display("FAIL oneshot_expire: got count=%0d busy=%0b done=%0b tz=%0b, want 0 0 1 0",
               count, busy, done, tz);
    end
    cycle();
    checks++;
    if ({count, busy, done} !== {WIDTH'(0), 2'b00}) begin
      errors++;
      $display("FAIL oneshot_hold: got count=%0d busy=%0b done=%0b, want 0 0 0", count, busy, done);
    end
  endtask

  task automatic test_reload_gaps();
    int pulses = 0;
    load = 1'b1; load_val = 4'd2; mode = MODE_RELOAD; enable = 1'b1;
    cycle();
    load = 1'b0;
    for (int i = 0; i < 12 * STEP_CYC; i++) begin
      enable = (i % 2 == 0);
      cycle();
      if (done) pulses++;
      checks++;
      if ({count, busy, done, tz} !== model_vec()) begin
        errors++;
        $display("FAIL reload_gaps: cycle %0d got {count,busy,done,tz}=%h, want %h",
                 i, {count, busy, done, tz}, model_vec());
      end
    end
    // 6*STEP_CYC enabled cycles -> 6 steps -> expiry on every 3rd step.
    checks++;
    if (pulses !== 2) begin
      errors++;
      $display("FAIL reload_pulses: got %0d done pulses, want 2", pulses);
    end
    enable = 1'b0; mode = MODE_ONESHOT;
  endtask

  task automatic test_clamp();
    int cyc = 0;
    load = 1'b1; load_val = 4'd12; mode = MODE_ONESHOT; enable = 1'b1;
    cycle();
    load = 1'b0;
    checks++;
    if (count !== 4'd9) begin
      errors++;
      $display("FAIL clamp_load: got count=%0d, want 9", count);
    end
    while (cyc < 20 * STEP_CYC + 5) begin
      cycle();
      cyc++;
      if (done) break;
    end
    checks++;
    if (cyc !== 10 * STEP_CYC || done !== 1'b1) begin
      errors++;
      $display("FAIL clamp_period: got done after %0d cycles (done=%0b), want %0d",
               cyc, done, 10 * STEP_CYC);
    end
  endtask

  task automatic test_load_at_expiry();
    load = 1'b1; load_val = 4'd0; mode = MODE_RELOAD; enable = 1'b1;
    cycle();
    checks++;
    if (tz !== 1'b1) begin
      errors++;
      $display("FAIL zero_load_tz: got tz=%0b, want 1", tz);
    end
    load_val = 4'd5;
    cycle();
    load = 1'b0;
    checks++;
    if ({count, busy, done} !== {WIDTH'(5), 2'b10}) begin
      errors++;
      $display("FAIL load_at_expiry: got count=%0d busy=%0b done=%0b, want 5 1 0", count, busy, done);
    end
    mode = MODE_ONESHOT; enable = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int cyc = 0;
    load = 1'b1; load_val = 4'd8; mode = MODE_ONESHOT; enable = 1'b1;
    cycle();
    load = 1'b0;
    while (count !== 4'd4 && cyc < 100) begin
      cycle();
      cyc++;
    end
    checks++;
    if (count !== 4'd4) begin
      errors++;
      $display("FAIL midrun_reach: got count=%0d after %0d cycles, want 4", count, cyc);
    end
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    checks++;
    if ({count, busy, done, tz} !== {WIDTH'(0), 3'b000}) begin
      errors++;
      $display("FAIL midrun_reset: got count=%0d busy=%0b done=%0b tz=%0b, want 0 0 0 0",
               count, busy, done, tz);
    end
  endtask

  task automatic test_expiry_timing();
    int cyc = 0;
    load = 1'b1; load_val = 4'd1; mode = MODE_ONESHOT; enable = 1'b1;
    cycle();
    load = 1'b0;
    while (cyc < 50) begin
      cycle();
      cyc++;
      if (done) break;
    end
    checks++;
    if (cyc !== 2 * STEP_CYC || done !== 1'b1) begin
      errors++;
      $display("FAIL expiry_timing: got done after %0d cycles (done=%0b), want %0d",
               cyc, done, 2 * STEP_CYC);
    end
    enable = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      reset_n = ($urandom_range(0, 99) >= 2);
      load = ($urandom_range(0, 99) < 8);
      load_val = WIDTH'($urandom_range(0, 15));
      enable = ($urandom_range(0, 99) < 75);
      if ($urandom_range(0, 9) == 0) mode = 1'($urandom_range(0, 1));
      cycle();
      checks++;
      if ({count, busy, done, tz} !== model_vec() || state !== (m_run ? RUN : IDLE)) begin
        errors++;
        $display("FAIL random: cycle %0d got {count,busy,done,tz}=%h state=%0d, want %h run=%0b",
                 i, {count, busy, done, tz}, state, model_vec(), m_run);
      end
    end
    reset_n = 1'b1; load = 1'b0; enable = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; load = 1'b0; load_val = '0; enable = 1'b0; mode = 1'b0;
    test_reset();
    test_oneshot();
    test_reload_gaps();
    test_clamp();
    test_load_at_expiry();
    test_reset_midrun();
    test_expiry_timing();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/modn_down_timer.md
# modn_down_timer

Synchronous mod-N down-counting timer, the decrementing counterpart to the team's mod-N up counter. It is loaded with a start value, counts down to zero on enabled cycles, and flags expiry. It then either stops (one-shot) or reloads its last start value (auto-reload). It sits beside the up counter in the counter library as the timeout and interval generator for control logic.

## Interface
- `N`, 10: modulus; legal count range is 0..N-1.
- `WIDTH`, `$clog2(N)`: counter width in bits.
- `PRESCALE`, 4: decrement divider; only used when `MODN_DOWN_PRESCALE_EN` is defined.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset, sampled on the `clk` rising edge.
- `load`  in  1  start or restart the timer with `load_val`.
- `load_val`  in  WIDTH  start value; clamped to N-1 when ≥ N.
- `enable`  in  1  count enable; the timer holds when low.
- `mode`  in  1  behaviour at expiry: 0 = one-shot, 1 = auto-reload; sampled at expiry.
- `count`  out  WIDTH  current value (registered).
- `busy`  out  1  high while in RUN (registered).
- `tz`  out  1  terminal zero, combinational: `busy && count == 0`.
- `done`  out  1  one-cycle expiry pulse (registered).

## Operation
- Reset (`reset_n` = 0 at an edge): state IDLE, `count` = 0, reload register = N-1, prescaler = 0.
  - Reset values of the outputs are `count` = 0, `busy` = 0, `done` = 0, `tz` = 0.
- States:
  - **IDLE**: `count` holds and `enable` is ignored. `load` sets count and reload register to `clamp(load_val)`, then goes to RUN.
  - **RUN**: `load` has priority; it reloads both registers with `clamp(load_val)`, stays in RUN and does not pulse `done`.
  - **RUN, step taken, `count` > 0**: `count` decrements by 1.
  - **RUN, step taken, `count` == 0**: `done` pulses for one cycle.
    - `mode` = 1: `count` is set to the reload register and the timer stays in RUN.
    - `mode` = 0: `count` stays 0 and the timer goes to IDLE.
  - **RUN, no step**: `count` holds.
- A step is `enable` = 1 when the prescaler is compiled out.
- `count` never leaves 0..N-1. There is no underflow wrap to 2^WIDTH-1.
- `load_val` = 0 is legal: the timer expires on the first step after the load.
- `done` is 0 in every cycle that is not an expiry edge.

## Timing
- `load` to `count` = `clamp(load_val)`: 1 cycle. `busy` rises on the same edge.
- Expiry period:
  - One-shot: `load_val`+1 steps after the load edge, `done` = 1 and `busy` = 0 on the same edge.
  - Auto-reload: `done` pulses every `load_val`+1 steps.
- `load` on the same edge as an expiry: load wins, no `done` pulse, `count` = new value.
- `reset_n` low mid-RUN: everything returns to the reset values on that edge. Any pending expiry is lost.
- `mode` change mid-run takes effect at the next expiry only.

## Configuration
- `MODN_DOWN_PRESCALE_EN` defined:
  - A step occurs once every `PRESCALE` cycles with `enable` = 1.
  - The prescaler clears on `load` and on reset.
  - The prescaler holds while `enable` = 0.
- `MODN_DOWN_PRESCALE_EN` undefined:
  - A step occurs on every cycle with `enable` = 1.
  - `PRESCALE` is unused and no prescaler flops exist.

## Structure
- The shared package holds:
  - the state enum (IDLE, RUN);
  - the `MODE_ONESHOT` = 0 and `MODE_RELOAD` = 1 constants.
- One sub-module, `modn_step_gen`, contains the prescaler.
  - Ports: `clk`, `reset_n`, `clr`, `enable`, `step`.
  - With the macro undefined it reduces to `step = enable`.
- The clamp function is local to the top.

## Test plan
All scenarios use N = 10, with the prescaler off unless stated.
- Reset check: hold `reset_n` = 0 for 2 cycles with random inputs -> `count` = 0, `busy` = 0, `done` = 0, `tz` = 0.
- One-shot: `load` with `load_val` = 3, `mode` = 0, `enable` = 1 -> `count` goes 3, 2, 1, 0; the next edge gives `done` = 1 and `busy` = 0; `count` then holds 0 with `done` = 0.
- Auto-reload with gaps: `load_val` = 2, `mode` = 1, `enable` toggled 1/0 -> `count` follows 2, 1, 0, 2…, advancing only on enabled cycles; `done` pulses every 3rd enabled cycle.
- Clamp: `load_val` = 12 -> `count` = 9; expiry follows after 10 steps.
- Load at expiry: assert `load` with `load_val` = 5 on the cycle where `tz` = 1 -> no `done` pulse, `count` = 5, `busy` = 1.
- Reset mid-run, then the prescaler (`MODN_DOWN_PRESCALE_EN`, `PRESCALE` = 4):
  - Drop `reset_n` at `count` = 4 -> `count` = 0 and `busy` = 0 on the next edge.
  - Then load 1 with `enable` = 1 -> `done` pulses 8 cycles after the load edge.
